// File: rtl/cpu_fetch.sv
// cpu_fetch -- instruction-fetch stage of the Rv32H pipeline.
//
// Fetches one 32-bit word per instruction over a request/ready bus. Each word
// is then published to decode as {tag, instruction, pc}. Decode consumes an
// instruction whenever o_tag changes and it is not stalled. After any
// control-flow or system instruction the stage parks until execute returns
// the resolved next PC, so no wrong-path word is ever published.
//
// Ports:
//   i_clock, i_reset         clock (rising edge), async active-high reset
//   i_stall                  downstream cannot take a new tag this cycle
//   i_jump_valid, i_jump_pc  resolved next PC from execute (one-cycle pulse)
//   o_bus_request            instruction bus request
//   o_bus_address            word address of the request, bits [1:0] = 0
//   i_bus_ready, i_bus_rdata read data valid / instruction word
//   o_tag                    increments once per published instruction
//   o_instruction, o_pc      published instruction and its PC
module cpu_fetch #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          TAG_WIDTH    = 4
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_stall,
    input  logic                 i_jump_valid,
    input  logic [31:0]          i_jump_pc,
    output logic                 o_bus_request,
    output logic [31:0]          o_bus_address,
    input  logic                 i_bus_ready,
    input  logic [31:0]          i_bus_rdata,
    output logic [TAG_WIDTH-1:0] o_tag,
    output logic [31:0]          o_instruction,
    output logic [31:0]          o_pc
);

    typedef enum logic [1:0] {
        S_FETCH     = 2'd0,
        S_PUBLISH   = 2'd1,
        S_WAIT_JUMP = 2'd2
    } state_t;

    localparam logic [31:0] RESET_PC = RESET_VECTOR & ~32'h3;

    state_t               state_q;
    logic [31:0]          pc_q;
    logic [31:0]          ibuf_q;
    logic                 req_q;
    logic [31:0]          addr_q;
    logic [TAG_WIDTH-1:0] tag_q;
    logic [31:0]          instr_q;
    logic [31:0]          opc_q;

    logic                 halt_d;
    logic [31:0]          pc_inc_d;
    logic [31:0]          jump_pc_d;

    // Branch, JAL, JALR and SYSTEM all leave the next PC unknown to fetch.
    always_comb begin
        halt_d = 1'b0;
        case (ibuf_q[6:0])
            7'b1100011, 7'b1101111, 7'b1100111, 7'b1110011: halt_d = 1'b1;
            default:                                         halt_d = 1'b0;
        endcase
        pc_inc_d  = pc_q + 32'd4;
        jump_pc_d = i_jump_pc & ~32'h3;
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ibuf_q  <= '0;
            req_q   <= 1'b0;
            addr_q  <= RESET_PC;
            tag_q   <= '0;
            instr_q <= '0;
            opc_q   <= '0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    // Request is idle only on the first cycle after reset;
                    // every later entry into FETCH raises it on the way in.
                    if (!req_q) begin
                        req_q  <= 1'b1;
                        addr_q <= pc_q;
                    end else if (i_bus_ready) begin
                        ibuf_q  <= i_bus_rdata;
                        req_q   <= 1'b0;
                        state_q <= S_PUBLISH;
                    end
                end
                S_PUBLISH: begin
                    if (!i_stall) begin
                        instr_q <= ibuf_q;
                        opc_q   <= pc_q;
                        tag_q   <= tag_q + 1'b1;
                        if (halt_d) begin
                            state_q <= S_WAIT_JUMP;
                        end else begin
                            pc_q    <= pc_inc_d;
                            addr_q  <= pc_inc_d;
                            req_q   <= 1'b1;
                            state_q <= S_FETCH;
                        end
                    end
                end
                S_WAIT_JUMP: begin
                    if (i_jump_valid) begin
                        pc_q    <= jump_pc_d;
                        addr_q  <= jump_pc_d;
                        req_q   <= 1'b1;
                        state_q <= S_FETCH;
                    end
                end
                default: state_q <= S_FETCH;
            endcase
        end
    end

    assign o_bus_request = req_q;
    assign o_bus_address = addr_q;
    assign o_tag         = tag_q;
    assign o_instruction = instr_q;
    assign o_pc          = opc_q;

endmodule

// File: tb/tb_cpu_fetch.sv
// Bench for cpu_fetch: two instances (TAG_WIDTH 4 and 2) share stimulus.
// Expected publications come from a program-order walk over a memory image;
// a negedge monitor pops and compares whenever o_tag changes.
module tb_cpu_fetch;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, stall, jv, rdy;
    logic [31:0] jpc, rdata;
    logic        req, req2;
    logic [31:0] addr, addr2, ins4, pc4, ins2, pc2;
    logic [3:0]  tag4;
    logic [1:0]  tag2;

    cpu_fetch #(.RESET_VECTOR(32'h0), .TAG_WIDTH(4)) dut (
        .i_clock(clk), .i_reset(rst), .i_stall(stall), .i_jump_valid(jv),
        .i_jump_pc(jpc), .o_bus_request(req), .o_bus_address(addr),
        .i_bus_ready(rdy), .i_bus_rdata(rdata), .o_tag(tag4),
        .o_instruction(ins4), .o_pc(pc4));

    cpu_fetch #(.RESET_VECTOR(32'h0), .TAG_WIDTH(2)) dut_t2 (
        .i_clock(clk), .i_reset(rst), .i_stall(stall), .i_jump_valid(jv),
        .i_jump_pc(jpc), .o_bus_request(req2), .o_bus_address(addr2),
        .i_bus_ready(rdy), .i_bus_rdata(rdata), .o_tag(tag2),
        .o_instruction(ins2), .o_pc(pc2));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed { logic [31:0] pc; logic [31:0] ins; } exp_t;
    logic [31:0] mem [256];
    exp_t        expq[$];
    logic [31:0] req_log[$];
    int          pub_cnt = 0;
    bit          pending = 1'b0;
    bit          chk_spacing = 1'b0;

    function automatic bit is_halt(input logic [31:0] w);
        case (w[6:0])
            7'h63, 7'h6F, 7'h67, 7'h73: return 1'b1;
            default:                    return 1'b0;
        endcase
    endfunction

    // Instructions execute in program order from start until the first
    // control-flow/system instruction, whose successor only execute knows.
    task automatic push_run(input logic [31:0] start);
        logic [31:0] p;
        exp_t        e;
        p = start;
        for (int k = 0; k < 300; k++) begin
            e.pc  = p;
            e.ins = mem[p[9:2]];
            expq.push_back(e);
            if (is_halt(e.ins)) break;
            p = p + 32'd4;
        end
    endtask

    task automatic model_reset();
        expq.delete();
        req_log.delete();
        pub_cnt = 0;
        pending = 1'b0;
    endtask

    // ---------------- bus responder ----------------
    int bus_delay = 0;
    bit bus_rand  = 1'b0;
    bit busy      = 1'b0;
    int wcnt      = 0;
    initial begin
        rdy = 1'b0; rdata = 32'h0;
        forever begin
            @(posedge clk); #1;
            if (rst || !req) begin
                busy = 1'b0; rdy = 1'b0; rdata = $urandom;
            end else begin
                if (!busy) begin
                    busy = 1'b1;
                    wcnt = bus_rand ? $urandom_range(0, 3) : bus_delay;
                end
                if (wcnt == 0) begin
                    rdy = 1'b1; rdata = mem[addr[9:2]];
                end else begin
                    rdy = 1'b0; rdata = $urandom; wcnt--;
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    bit          stall_s;
    always @(posedge clk) stall_s <= stall;

    int          cyc = 0, last_pub_cyc = 0;
    logic [3:0]  last_tag;
    logic [31:0] last_ins, last_pc, last_addr;
    bit          last_req = 1'b0, last_rdy = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!rst) begin
            if (tag4 !== last_tag) begin
                chk("tag_under_stall", {31'b0, stall_s}, 32'd0);
                if (expq.size() == 0) begin
                    chk("unexpected_publish_pc", pc4, 32'hxxxx_xxxx);
                end else begin
                    e = expq.pop_front();
                    pub_cnt++;
                    chk("pub_pc", pc4, e.pc);
                    chk("pub_instr", ins4, e.ins);
                    chk("pub_tag4", {28'b0, tag4}, pub_cnt % 16);
                    chk("pub_tag2", {30'b0, tag2}, pub_cnt % 4);
                    chk("pub_pc_t2", pc2, e.pc);
                    chk("pub_instr_t2", ins2, e.ins);
                    if (chk_spacing && pub_cnt > 1)
                        chk("publish_spacing", cyc - last_pub_cyc, 32'd2);
                    last_pub_cyc = cyc;
                    if (is_halt(e.ins)) pending = 1'b1;
                end
            end else begin
                chk("frozen_outputs", {31'b0, (ins4 === last_ins) && (pc4 === last_pc)}, 32'd1);
            end
            chk("addr_align", {30'b0, addr[1:0] | addr2[1:0]}, 32'd0);
            if (last_req && !last_rdy)
                chk("bus_hold", {31'b0, req && (addr === last_addr)}, 32'd1);
            if (req && !last_req) req_log.push_back(addr);
            if (pending) chk("req_in_wait_jump", {31'b0, req | req2}, 32'd0);
        end
        last_tag  = tag4;  last_ins = ins4; last_pc = pc4;
        last_addr = addr;
        last_req  = rst ? 1'b0 : req;
        last_rdy  = rst ? 1'b0 : rdy;
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        step();
        rst = 1'b1; stall = 1'b0; jv = 1'b0;
        #1;
        chk("rst_req", {31'b0, req}, 32'd0);
        chk("rst_addr", addr, 32'h0);
        chk("rst_tag", {28'b0, tag4}, 32'd0);
        chk("rst_instr", ins4, 32'h0);
        chk("rst_pc", pc4, 32'h0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        push_run(32'h0);
    endtask

    task automatic fill_nop();
        for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0013;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        logic [31:0] t;
        logic [6:0]  ops [9];
        ops = '{7'h13, 7'h33, 7'h03, 7'h23, 7'h37, 7'h63, 7'h6F, 7'h67, 7'h73};
        rst = 1'b1; stall = 1'b0; jv = 1'b0; jpc = 32'h0;
        fill_nop();

        // Zero-wait sequential fetch: one publish per 2 cycles.
        bus_delay = 0;
        do_reset();
        chk_spacing = 1'b1;
        repeat (14) step();
        chk_spacing = 1'b0;
        chk("zero_wait_pubs", pub_cnt, 32'd6);
        chk("req_log_len", {31'b0, req_log.size() >= 3}, 32'd1);
        if (req_log.size() >= 3) begin
            chk("req0_addr", req_log[0], 32'h0);
            chk("req1_addr", req_log[1], 32'h4);
            chk("req2_addr", req_log[2], 32'h8);
        end

        // Ready delayed 3 cycles.
        bus_delay = 3;
        do_reset();
        @(posedge clk);
        n = 0;
        repeat (5) begin
            @(negedge clk);
            if (req && !rdy) n++;
            if (req) chk("delay_addr", addr, 32'h0);
        end
        chk("delay_wait_cycles", n, 32'd3);
        @(negedge clk);
        chk("delay_one_inc", {28'b0, tag4}, 32'd1);
        repeat (4) @(negedge clk);
        chk("delay_no_extra_inc", {28'b0, tag4}, 32'd1);

        // Stall 5 cycles in PUBLISH.
        bus_delay = 0;
        do_reset();
        step(); step();
        stall = 1'b1;
        repeat (5) begin
            step();
            chk("stall_no_req", {31'b0, req}, 32'd0);
            chk("stall_tag", {28'b0, tag4}, 32'd0);
            chk("stall_instr", ins4, 32'h0);
        end
        stall = 1'b0;
        step();
        chk("stall_release_tag", {28'b0, tag4}, 32'd1);
        chk("stall_release_req", {31'b0, req}, 32'd1);

        // JAL at 0x8, then jump to 0x102 -> fetch at 0x100.
        mem[2] = 32'h0000_006F;
        do_reset();
        n = 0;
        while (!pending && n < 40) begin step(); n++; end
        chk("jal_published", {31'b0, pending}, 32'd1);
        repeat (4) begin
            step();
            chk("jal_req_low", {31'b0, req}, 32'd0);
        end
        jv = 1'b1; jpc = 32'h102; pending = 1'b0;
        push_run(32'h100);
        step();
        jv = 1'b0;
        chk("jump_req", {31'b0, req}, 32'd1);
        chk("jump_addr", addr, 32'h100);
        n = 0;
        while (pub_cnt < 4 && n < 10) begin step(); n++; end
        chk("jump_pub_pc", pc4, 32'h100);
        mem[2] = 32'h0000_0013;

        // Reset mid-request at 0x40.
        bus_delay = 3;
        do_reset();
        n = 0;
        while (!(req && addr == 32'h40) && n < 300) begin step(); n++; end
        chk("reach_0x40", {31'b0, n < 300}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_req_drop", {31'b0, req}, 32'd0);
        chk("async_addr", addr, 32'h0);
        chk("async_tag", {28'b0, tag4}, 32'd0);
        chk("async_pc", pc4, 32'h0);
        chk("async_instr", ins4, 32'h0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        push_run(32'h0);
        step();
        chk("restart_req", {31'b0, req}, 32'd1);
        chk("restart_addr", addr, 32'h0);
        repeat (8) step();
        chk("restart_tag", {28'b0, tag4}, 32'd1);

        // Randomized program, bus latency, stalls and jumps.
        for (int i = 0; i < 256; i++)
            mem[i] = ($urandom & 32'hFFFF_FF80) | {25'b0, ops[$urandom_range(0, 8)]};
        bus_rand = 1'b1;
        do_reset();
        repeat (3000) begin
            step();
            stall = ($urandom_range(0, 3) == 0);
            jv    = 1'b0;
            if (pending && $urandom_range(0, 2) == 0) begin
                t = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFD : $urandom;
                jv = 1'b1; jpc = t; pending = 1'b0;
                push_run(t & ~32'h3);
            end else if (req && $urandom_range(0, 15) == 0) begin
                // Jump while fetching is a protocol violation and must be ignored.
                jv = 1'b1; jpc = $urandom;
            end
        end
        jv = 1'b0; stall = 1'b0;
        chk("random_progress", {31'b0, pub_cnt > 200}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cpu_fetch.md
Name: cpu_fetch

Overview:
- Instruction-fetch stage of the Rv32H pipeline, directly upstream of the decode stage.
- Reads one 32-bit word per instruction over a request/ready instruction bus.
- Publishes {tag, instruction, pc} with the pipeline tag handshake: the downstream stage consumes whenever o_tag changes and it is not stalled.
- Halts after any control-flow or system instruction until execute supplies the next PC, so no wrong-path instruction is ever published.

Parameters:
- RESET_VECTOR, 32'h00000000, PC of the first fetch after reset.
- TAG_WIDTH, 4, width of o_tag; equals the pipeline tag width.

Ports:
- i_clock  in  1  clock, rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_stall  in  1  downstream cannot accept a new tag this cycle.
- i_jump_valid  in  1  one-cycle pulse from execute carrying the resolved next PC.
- i_jump_pc  in  32  next PC after a halting instruction (taken or not taken).
- o_bus_request  out  1  instruction bus request.
- o_bus_address  out  32  word address; bits [1:0] always 0.
- i_bus_ready  in  1  read data valid; transaction complete.
- i_bus_rdata  in  32  instruction word.
- o_tag  out  TAG_WIDTH  changes exactly once per published instruction.
- o_instruction  out  32  published instruction.
- o_pc  out  32  PC of the published instruction.

Behaviour:
- Reset (asynchronous, immediate):
  - State FETCH; pc = RESET_VECTOR with bits [1:0] cleared.
  - o_tag = 0, o_instruction = 0, o_pc = 0.
  - o_bus_request = 0; o_bus_address = RESET_VECTOR & ~3.
  - An in-flight bus request is abandoned; the bus tolerates request dropping.
- Request on the first edge after reset release: o_bus_request = 1 and o_bus_address = pc, registered.
- FETCH state:
  - o_bus_request and o_bus_address are held stable until the edge sampling i_bus_ready = 1.
  - On that edge: buf <= i_bus_rdata, o_bus_request <= 0, go to PUBLISH.
  - i_stall is ignored in FETCH.
- PUBLISH state:
  - If i_stall = 1, hold state and all outputs.
  - Otherwise, on the edge: o_instruction <= buf, o_pc <= pc, o_tag <= o_tag + 1 (modulo 2^TAG_WIDTH; wrap to 0 is legal).
  - Next state, decided from buf[6:0]:
    - 1100011 (branch), 1101111 (JAL), 1100111 (JALR) or 1110011 (SYSTEM): go to WAIT_JUMP; pc is unchanged.
    - Any other opcode: pc <= pc + 4 (32-bit wrap), go to FETCH and assert the next request on the same edge.
- WAIT_JUMP state:
  - o_bus_request = 0.
  - On i_jump_valid = 1: pc <= i_jump_pc & ~3, go to FETCH, assert the request on the same edge.
- i_jump_valid in FETCH or PUBLISH is ignored (protocol violation; no state change).
- o_tag never changes while i_stall = 1, so downstream cannot miss an instruction.
- Latency and throughput:
  - Ready sampled at edge N; the tag is published at edge N+1 if not stalled.
  - The next request is asserted at edge N+1.
  - Zero-wait bus: one instruction per 2 cycles.
- The bus data word is captured only on the ready edge; i_bus_rdata is don't-care at other times.

Test Plan:
- Reset release, zero-wait bus returning 32'h00000013 at every address:
  - Requests at 0x0, 0x4, 0x8.
  - o_tag goes 1, 2, 3 with o_pc 0x0, 0x4, 0x8.
  - One publish every 2 cycles.
- Ready delayed 3 cycles: o_bus_address stays 0x0 with request high for 3 cycles; exactly one tag increment follows.
- i_stall held high 5 cycles in PUBLISH:
  - o_tag and o_instruction are frozen.
  - Publish occurs on the first edge after i_stall falls; no extra bus request is issued.
- Fetch of 32'h0000006F (JAL) at 0x8:
  - Published, then request stays low.
  - i_jump_valid with i_jump_pc = 0x102 → next request at address 0x100; published o_pc = 0x100.
- TAG_WIDTH = 2, 5 sequential instructions: o_tag sequence 1, 2, 3, 0, 1.
- Reset asserted mid-request at 0x40:
  - o_bus_request falls without a clock edge.
  - After release, fetch restarts at RESET_VECTOR with o_tag = 0.
